// File: rtl/bw_io_ddr_pkg.sv
// Shared definitions for the DDR pad-ring repeaters: default sizes,
// read-return framing states and the per-byte parity helper.
package bw_io_ddr_pkg;

  localparam int DEF_DW    = 64;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_BURST = 4;

  typedef enum logic {
    RDRET_IDLE   = 1'b0,
    RDRET_ACTIVE = 1'b1
  } rdret_state_e;

  // Even parity over one byte: result is 1 when the byte has an odd number of ones.
  function automatic logic byte_par(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/bw_io_ddr_rdret_fifo.sv
// Synchronous FIFO with occupancy counter. The head comes straight from
// storage at the read pointer and reads as zero while the FIFO is empty.
module bw_io_ddr_rdret_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bw_io_ddr_rdret_rptr.sv
// Read-return repeater: two retiming stages from the pads, per-byte parity
// check, burst framing, and a small FIFO toward the DRAM controller.
module bw_io_ddr_rdret_rptr
  import bw_io_ddr_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int DEPTH = DEF_DEPTH,
  parameter int BURST = DEF_BURST
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pad_vld,
  input  logic [DW-1:0]   pad_data,
  input  logic [DW/8-1:0] pad_par,
  output logic            ctl_vld,
  input  logic            ctl_rdy,
  output logic [DW-1:0]   ctl_data,
  output logic            ctl_last,
  output logic [DW/8-1:0] ctl_perr,
  output logic            ovf_err,
  output logic            burst_err
);

  localparam int NB = DW / 8;
  localparam int BW = $clog2(BURST);
  localparam int FW = DW + 1 + NB;

  logic            s0_vld, s1_vld;
  logic [DW-1:0]   s0_data, s1_data;
  logic [NB-1:0]   s0_par, s1_par;
  logic [NB-1:0]   perr;
  logic [BW-1:0]   beat;
  logic            last;
  rdret_state_e    state;
  logic            full, empty, push, pop;
  logic [FW-1:0]   head;

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_vld  <= 1'b0;
      s0_data <= '0;
      s0_par  <= '0;
      s1_vld  <= 1'b0;
      s1_data <= '0;
      s1_par  <= '0;
    end else begin
      s0_vld  <= pad_vld;
      s0_data <= pad_data;
      s0_par  <= pad_par;
      s1_vld  <= s0_vld;
      s1_data <= s0_data;
      s1_par  <= s0_par;
    end
  end

  always_comb begin
    perr = '0;
    for (int i = 0; i < NB; i++) perr[i] = byte_par(s1_data[8*i +: 8]) ^ s1_par[i];
  end

  assign last = (beat == BW'(BURST - 1));

  // Handshake: a head beat transfers on any cycle where ctl_vld && ctl_rdy;
  // ctl_vld is a pure function of FIFO state and never looks at ctl_rdy.
  // The pad side cannot stall, so a full FIFO without a pop drops the beat.
  assign pop  = ctl_vld & ctl_rdy;
  assign push = s1_vld & (~full | pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RDRET_IDLE;
      beat      <= '0;
      ovf_err   <= 1'b0;
      burst_err <= 1'b0;
    end else begin
      if (s1_vld && full && !pop) ovf_err <= 1'b1;
      case (state)
        RDRET_IDLE: begin
          if (s1_vld) begin
            state <= RDRET_ACTIVE;
            beat  <= BW'(1);
          end
        end
        RDRET_ACTIVE: begin
          if (!s1_vld) begin
            burst_err <= 1'b1;
            state     <= RDRET_IDLE;
            beat      <= '0;
          end else if (last) begin
            state <= RDRET_IDLE;
            beat  <= '0;
          end else begin
            beat <= beat + BW'(1);
          end
        end
        default: begin
          state <= RDRET_IDLE;
          beat  <= '0;
        end
      endcase
    end
  end

  bw_io_ddr_rdret_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({s1_data, last, perr}),
    .pop   (pop),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  assign ctl_vld                      = ~empty;
  assign {ctl_data, ctl_last, ctl_perr} = head;

endmodule

// File: tb/tb_bw_io_ddr_rdret_rptr.sv
// Directed bench for the read-return repeater: framing, parity, overflow,
// full-with-pop and reset-discard cases with hand-computed expectations.
module tb_bw_io_ddr_rdret_rptr;

  logic        clk = 1'b0;
  logic        rst;
  logic        pad_vld;
  logic [63:0] pad_data;
  logic [7:0]  pad_par;
  logic        ctl_vld;
  logic        ctl_rdy;
  logic [63:0] ctl_data;
  logic        ctl_last;
  logic [7:0]  ctl_perr;
  logic        ovf_err;
  logic        burst_err;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  bw_io_ddr_rdret_rptr dut (
    .clk       (clk),
    .rst       (rst),
    .pad_vld   (pad_vld),
    .pad_data  (pad_data),
    .pad_par   (pad_par),
    .ctl_vld   (ctl_vld),
    .ctl_rdy   (ctl_rdy),
    .ctl_data  (ctl_data),
    .ctl_last  (ctl_last),
    .ctl_perr  (ctl_perr),
    .ovf_err   (ovf_err),
    .burst_err (burst_err)
  );

  function automatic logic [7:0] even_par(input logic [63:0] d);
    logic [7:0] p;
    for (int i = 0; i < 8; i++) p[i] = ^d[8*i +: 8];
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [63:0] d, input logic [7:0] flip);
    pad_vld  = 1'b1;
    pad_data = d;
    pad_par  = even_par(d) ^ flip;
    tick();
  endtask

  task automatic idle();
    pad_vld  = 1'b0;
    pad_data = '0;
    pad_par  = '0;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    idle();
    rst = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [63:0] d, input logic l,
                          input logic [7:0] p);
    chk({tag, "_vld"},  ctl_vld,  1'b1);
    chk({tag, "_data"}, ctl_data, d);
    chk({tag, "_last"}, ctl_last, l);
    chk({tag, "_perr"}, ctl_perr, p);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst      = 1'b1;
    pad_vld  = 1'b0;
    pad_data = '0;
    pad_par  = '0;
    ctl_rdy  = 1'b0;
    tick();
    tick();
    chk("rst_vld",   ctl_vld,   1'b0);
    chk("rst_data",  ctl_data,  64'h0);
    chk("rst_last",  ctl_last,  1'b0);
    chk("rst_perr",  ctl_perr,  8'h0);
    chk("rst_ovf",   ovf_err,   1'b0);
    chk("rst_burst", burst_err, 1'b0);
    rst = 1'b0;
    idle();
    idle();

    // Single clean burst, controller always ready: 3-cycle latency, last on beat 4.
    ctl_rdy = 1'b1;
    drive(64'h1, 8'h0);
    drive(64'h2, 8'h0);
    drive(64'h3, 8'h0);
    chk_head("t1_b1", 64'h1, 1'b0, 8'h0);
    drive(64'h4, 8'h0);
    chk_head("t1_b2", 64'h2, 1'b0, 8'h0);
    idle();
    chk_head("t1_b3", 64'h3, 1'b0, 8'h0);
    idle();
    chk_head("t1_b4", 64'h4, 1'b1, 8'h0);
    idle();
    chk("t1_empty", ctl_vld,   1'b0);
    chk("t1_ovf",   ovf_err,   1'b0);
    chk("t1_burst", burst_err, 1'b0);

    // Parity fault on byte 2 of beat 2.
    drive(64'h0102_0304_0506_0708, 8'h00);
    drive(64'h1111_2222_3333_4444, 8'h04);
    drive(64'hFFFF_0000_AAAA_5555, 8'h00);
    chk_head("t2_b1", 64'h0102_0304_0506_0708, 1'b0, 8'h00);
    drive(64'h8000_0000_0000_0001, 8'h00);
    chk_head("t2_b2", 64'h1111_2222_3333_4444, 1'b0, 8'h04);
    idle();
    chk_head("t2_b3", 64'hFFFF_0000_AAAA_5555, 1'b0, 8'h00);
    idle();
    chk_head("t2_b4", 64'h8000_0000_0000_0001, 1'b1, 8'h00);
    idle();
    chk("t2_empty", ctl_vld, 1'b0);

    // Overflow: two bursts into a stalled controller, second burst dropped.
    do_reset();
    ctl_rdy = 1'b0;
    for (int i = 0; i < 8; i++) drive(64'h100 + 64'(i), 8'h0);
    idle();
    idle();
    idle();
    chk("t3_ovf",   ovf_err,   1'b1);
    chk("t3_burst", burst_err, 1'b0);
    chk_head("t3_b1", 64'h100, 1'b0, 8'h0);
    ctl_rdy = 1'b1;
    idle();
    chk_head("t3_b2", 64'h101, 1'b0, 8'h0);
    idle();
    chk_head("t3_b3", 64'h102, 1'b0, 8'h0);
    idle();
    chk_head("t3_b4", 64'h103, 1'b1, 8'h0);
    idle();
    chk("t3_empty",   ctl_vld, 1'b0);
    chk("t3_ovf_stk", ovf_err, 1'b1);

    // Short burst of 3 beats, then a correctly framed full burst.
    do_reset();
    ctl_rdy = 1'b1;
    drive(64'h200, 8'h0);
    drive(64'h201, 8'h0);
    drive(64'h202, 8'h0);
    chk_head("t4_b1", 64'h200, 1'b0, 8'h0);
    idle();
    chk_head("t4_b2", 64'h201, 1'b0, 8'h0);
    chk("t4_burst_early0", burst_err, 1'b0);
    idle();
    chk_head("t4_b3", 64'h202, 1'b0, 8'h0);
    chk("t4_burst_early1", burst_err, 1'b0);
    idle();
    chk("t4_empty", ctl_vld,   1'b0);
    chk("t4_burst", burst_err, 1'b1);
    drive(64'h300, 8'h0);
    drive(64'h301, 8'h0);
    drive(64'h302, 8'h0);
    chk_head("t4_f1", 64'h300, 1'b0, 8'h0);
    drive(64'h303, 8'h0);
    chk_head("t4_f2", 64'h301, 1'b0, 8'h0);
    idle();
    chk_head("t4_f3", 64'h302, 1'b0, 8'h0);
    idle();
    chk_head("t4_f4", 64'h303, 1'b1, 8'h0);
    chk("t4_ovf", ovf_err, 1'b0);

    // Full FIFO with a pop in every cycle a new beat lands: nothing dropped.
    do_reset();
    ctl_rdy = 1'b0;
    for (int i = 0; i < 4; i++) drive(64'h400 + 64'(i), 8'h0);
    idle();
    idle();
    idle();
    chk_head("t5_full", 64'h400, 1'b0, 8'h0);
    drive(64'h404, 8'h0);
    drive(64'h405, 8'h0);
    ctl_rdy = 1'b1;
    drive(64'h406, 8'h0);
    chk_head("t5_h401", 64'h401, 1'b0, 8'h0);
    drive(64'h407, 8'h0);
    idle();
    idle();
    chk("t5_ovf", ovf_err, 1'b0);
    chk_head("t5_n1", 64'h404, 1'b0, 8'h0);
    idle();
    chk_head("t5_n2", 64'h405, 1'b0, 8'h0);
    idle();
    chk_head("t5_n3", 64'h406, 1'b0, 8'h0);
    idle();
    chk_head("t5_n4", 64'h407, 1'b1, 8'h0);
    idle();
    chk("t5_empty", ctl_vld,   1'b0);
    chk("t5_ovf2",  ovf_err,   1'b0);
    chk("t5_burst", burst_err, 1'b0);

    // Reset mid-burst with two entries queued discards everything silently.
    ctl_rdy = 1'b0;
    drive(64'h500, 8'h0);
    drive(64'h501, 8'h0);
    idle();
    idle();
    chk_head("t6_q", 64'h500, 1'b0, 8'h0);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    chk("t6_vld",   ctl_vld,   1'b0);
    chk("t6_burst", burst_err, 1'b0);
    chk("t6_ovf",   ovf_err,   1'b0);
    idle();
    chk("t6_burst2", burst_err, 1'b0);
    ctl_rdy = 1'b1;
    drive(64'h600, 8'h0);
    drive(64'h601, 8'h0);
    drive(64'h602, 8'h0);
    chk_head("t6_b1", 64'h600, 1'b0, 8'h0);
    drive(64'h603, 8'h0);
    chk_head("t6_b2", 64'h601, 1'b0, 8'h0);
    idle();
    chk_head("t6_b3", 64'h602, 1'b0, 8'h0);
    idle();
    chk_head("t6_b4", 64'h603, 1'b1, 8'h0);
    idle();
    chk("t6_empty",  ctl_vld,   1'b0);
    chk("t6_burst3", burst_err, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bw_io_ddr_rdret_rptr.md
# bw_io_ddr_rdret_rptr

Read-return repeater for the DDR pad ring: the inbound counterpart of the outbound address/control/data repeater. Retimes read-data beats coming from the pad side through two register stages and checks per-byte even parity. Tracks burst framing and buffers beats in a small FIFO. Presents them to the DRAM controller on a valid/ready handshake. The pad side has no backpressure; loss and framing faults are flagged with sticky error bits.

## Interface
Parameters:
- `DW`, 64, read-data width in bits; must be a multiple of 8.
- `DEPTH`, 4, FIFO entries; power of two, ≥2.
- `BURST`, 4, beats per read burst; power of two, ≥2.

Ports:
- `clk`  in  1  single clock for the whole block.
- `rst`  in  1  reset; synchronous, active-high.
- `pad_vld`  in  1  beat present on `pad_data` this cycle.
- `pad_data`  in  DW  read-data beat from pad receivers.
- `pad_par`  in  DW/8  even-parity bit per byte of `pad_data`.
- `ctl_vld`  out  1  FIFO head valid toward controller.
- `ctl_rdy`  in  1  controller accepts head this cycle.
- `ctl_data`  out  DW  head beat data.
- `ctl_last`  out  1  head is final beat of its burst.
- `ctl_perr`  out  DW/8  per-byte parity mismatch of head beat.
- `ovf_err`  out  1  sticky: a beat was dropped because the FIFO was full.
- `burst_err`  out  1  sticky: a burst ended with fewer than BURST beats.

## Operation
- S0: `pad_vld`, `pad_data`, `pad_par` registered unconditionally every cycle.
- S1: S0 contents registered again. Parity computed from S1 data: `perr[i] = ^data[8i+7:8i] ^ par[i]`.
- Beat counter `beat` has width log2(BURST). It increments on each S1 valid beat and wraps BURST-1 → 0. `last = (beat == BURST-1)`.
- Framing FSM on S1 valid:
  - IDLE: valid → ACTIVE, `beat` = 1.
  - ACTIVE: valid with `last` → IDLE, `beat` = 0. Valid without `last` → increment `beat`. Invalid → set `burst_err`, IDLE, `beat` = 0.
  - With BURST beats back-to-back, the first beat of the next burst is taken from IDLE in the following cycle.
- FIFO push = S1 valid and (not full, or pop in the same cycle). Entry stores {data, last, perr}. The `last` bit is the one computed for that beat.
- FIFO pop = `ctl_vld & ctl_rdy`.
- Push blocked (S1 valid and full with no pop): beat dropped, `ovf_err` set. The framing FSM and counter still advance, so later beats keep correct `last` alignment.
- Simultaneous push and pop when empty: the pushed entry becomes visible next cycle, not bypassed.
- Sticky errors clear only on `rst`.

## Timing
- Reset values, all outputs: `ctl_vld`=0, `ctl_data`=0, `ctl_last`=0, `ctl_perr`=0, `ovf_err`=0, `burst_err`=0.
- Reset state: S0/S1 valid=0, FSM=IDLE, `beat`=0, FIFO empty, pointers 0.
- Reset asserted mid-burst or with FIFO occupied: all state is discarded in that cycle, and no error is flagged.
- Latency: `pad_vld` high in cycle N → S0 valid N+1 → S1 valid N+2, FIFO write at end of N+2 → `ctl_vld` in N+3 when the FIFO was empty.
- Throughput: one beat per cycle sustained when `ctl_rdy` is held high.
- Outputs `ctl_*` are driven directly from FIFO storage and the read pointer, with no combinational path from `pad_*`.
- `ctl_vld` must not depend combinationally on `ctl_rdy`.
- Occupancy counter has width log2(DEPTH)+1 and reaches exactly DEPTH when full. Pointers wrap modulo DEPTH.

## Structure
- Shared package `bw_io_ddr_pkg`: framing FSM enum (`RDRET_IDLE`, `RDRET_ACTIVE`), default DW/DEPTH/BURST constants, and a parity function `byte_par`.
- One sub-module `bw_io_ddr_rdret_fifo`: parameterised width/depth synchronous FIFO with push/pop, full/empty, and registered head. It is instantiated once with width DW+1+DW/8.
- Top level holds S0/S1, the parity check, the framing FSM and the error flags.

## Test plan
- Single burst, `ctl_rdy`=1: 4 beats 0x1, 0x2, 0x3, 0x4 at cycles 10–13 with correct parity → `ctl_vld` at 13–16 with the same data, `ctl_last` only on 0x4, no errors.
- Parity fault: byte 2 parity inverted on beat 2 → that beat shows `ctl_perr`=0x04 and all others 0x00.
- Backpressure/overflow: `ctl_rdy`=0, two back-to-back bursts (8 beats) → first 4 beats held in the FIFO and the rest dropped, `ovf_err`=1. Then `ctl_rdy`=1 → exactly 4 beats out, the 4th with `last`=1.
- Short burst: 3 beats followed by an idle cycle → `burst_err`=1 one cycle after S1 sees the gap; a following full burst is framed correctly.
- Full with simultaneous pop: FIFO at 4 entries, `ctl_rdy`=1 and new beat arriving in the same cycle → no drop, occupancy stays 4, `ovf_err`=0.
- Reset mid-burst: `rst` after beat 2 with 2 entries queued → next cycle `ctl_vld`=0 and errors 0. A new 4-beat burst then delivers `last` on its 4th beat.
